cache_write_buffer: RTL and testbench

Posted-write FIFO between the set_associative_cache memory-side port and ram_mux port1, ahead of sp_ram_wrap. Cache writes (write-through and evictions) are acknowledged immediately and drained to memory in the background. Reads stall until all buffered and in-flight writes have completed, then pass through to memory. All writes, and the read that follows them, reach memory strictly in program order.

---
 rtl/cache_write_buffer.sv | 119 +++++++++++
 tb/tb_cache_write_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_write_buffer.sv
// Posted-write FIFO between the cache memory port and RAM. Writes are acked at once and
// drained in order; reads wait until all buffered and in-flight writes have completed.
module cache_write_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cache_req_i,
    input  logic [ADDR_WIDTH-1:0]   cache_addr_i,
    input  logic                    cache_we_i,
    input  logic [DATA_WIDTH/8-1:0] cache_be_i,
    input  logic [DATA_WIDTH-1:0]   cache_wdata_i,
    output logic                    cache_gnt_o,
    output logic                    cache_rvalid_o,
    output logic [DATA_WIDTH-1:0]   cache_rdata_o,
    output logic                    cache_error_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_error_i,
    output logic                    wr_error_o,
    output logic                    empty_o
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fifo_addr  [DEPTH];
    logic [BE_WIDTH-1:0]   fifo_be    [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [1:0]            wr_out_q;
    logic                  read_pending_q;
    logic                  rvalid_q, error_q, wr_error_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic full, not_empty, wr_rsp, drain, read_ok, push, pop, rd_req, rd_gnt;

    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        not_empty = (count_q != '0);
        // While a read is pending the only possible response is the read's own.
        wr_rsp    = mem_rvalid_i & (wr_out_q != 2'd0) & ~read_pending_q;
        // Hold off draining rather than overflow the outstanding-write counter.
        drain     = ~reset & not_empty & ~read_pending_q & ((wr_out_q != 2'd3) | wr_rsp);
        read_ok   = ~reset & ~not_empty & ~read_pending_q &
                    ((wr_out_q == 2'd0) | ((wr_out_q == 2'd1) & wr_rsp));
        push      = ~reset & cache_req_i & cache_we_i & ~full & ~read_pending_q;
        rd_req    = read_ok & cache_req_i & ~cache_we_i;
        pop       = drain & mem_gnt_i;
        rd_gnt    = rd_req & mem_gnt_i;

        cache_gnt_o = push | rd_gnt;
        mem_req_o   = drain | rd_req;
        mem_we_o    = drain;
        mem_addr_o  = drain ? fifo_addr[rd_ptr_q]  : cache_addr_i;
        mem_be_o    = drain ? fifo_be[rd_ptr_q]    : cache_be_i;
        mem_wdata_o = drain ? fifo_wdata[rd_ptr_q] : cache_wdata_i;

        cache_rvalid_o = rvalid_q;
        cache_rdata_o  = rdata_q;
        cache_error_o  = error_q;
        wr_error_o     = wr_error_q;
        empty_o        = ~not_empty & (wr_out_q == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q]  <= cache_addr_i;
            fifo_be[wr_ptr_q]    <= cache_be_i;
            fifo_wdata[wr_ptr_q] <= cache_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            wr_out_q       <= 2'd0;
            read_pending_q <= 1'b0;
            rvalid_q       <= 1'b0;
            error_q        <= 1'b0;
            rdata_q        <= '0;
            wr_error_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;

            if (pop && !wr_rsp)      wr_out_q <= wr_out_q + 2'd1;
            else if (wr_rsp && !pop) wr_out_q <= wr_out_q - 2'd1;

            if (wr_rsp && mem_error_i) wr_error_q <= 1'b1;

            if (rd_gnt) read_pending_q <= 1'b1;
            else if (read_pending_q && mem_rvalid_i) read_pending_q <= 1'b0;

            rvalid_q <= push | (read_pending_q & mem_rvalid_i);
            if (read_pending_q && mem_rvalid_i) begin
                rdata_q <= mem_rdata_i;
                error_q <= mem_error_i;
            end else if (push) begin
                error_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer: inputs are driven 1 ns after each rising edge and
// outputs sampled 1 ns later, with memory handshakes driven by hand.
module tb_cache_write_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        cache_req_i, cache_we_i;
    logic [31:0] cache_addr_i, cache_wdata_i;
    logic [3:0]  cache_be_i;
    logic        cache_gnt_o, cache_rvalid_o, cache_error_o;
    logic [31:0] cache_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_error_i;
    logic [31:0] mem_rdata_i;
    logic        wr_error_o, empty_o;

    int n_cmp = 0;
    int n_err = 0;

    cache_write_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .cache_req_i(cache_req_i), .cache_addr_i(cache_addr_i), .cache_we_i(cache_we_i),
        .cache_be_i(cache_be_i), .cache_wdata_i(cache_wdata_i), .cache_gnt_o(cache_gnt_o),
        .cache_rvalid_o(cache_rvalid_o), .cache_rdata_o(cache_rdata_o),
        .cache_error_o(cache_error_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mem_error_i(mem_error_i), .wr_error_o(wr_error_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cache_req_i = 1'b1; cache_we_i = 1'b1; cache_addr_i = a; cache_wdata_i = d;
        cache_be_i = 4'hF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_error_i = 1'b0;
        mem_rdata_i = '0;
        wr(32'h0010_0000, 32'h1);
        #2;
        chk("rst_gnt", cache_gnt_o, 0);
        chk("rst_rvalid", cache_rvalid_o, 0);
        chk("rst_rdata", cache_rdata_o, 0);
        chk("rst_err", cache_error_o, 0);
        chk("rst_mreq", mem_req_o, 0);
        chk("rst_wrerr", wr_error_o, 0);
        chk("rst_empty", empty_o, 1);
        tick();
        reset = 1'b0; cache_req_i = 1'b0;

        // Single write, memory not granting
        tick();
        wr(32'h0010_0000, 32'h1234_ABCD);
        #1;
        chk("w1_gnt", cache_gnt_o, 1);
        chk("w1_mreq_pre", mem_req_o, 0);
        tick();
        cache_req_i = 1'b0;
        #1;
        chk("w1_rvalid", cache_rvalid_o, 1);
        chk("w1_err", cache_error_o, 0);
        chk("w1_mreq", mem_req_o, 1);
        chk("w1_mwe", mem_we_o, 1);
        chk("w1_maddr", mem_addr_o, 32'h0010_0000);
        chk("w1_mdata", mem_wdata_o, 32'h1234_ABCD);
        chk("w1_mbe", mem_be_o, 4'hF);
        chk("w1_nempty", empty_o, 0);
        tick();
        chk("w1_rvalid_1cyc", cache_rvalid_o, 0);
        chk("w1_mreq_held", mem_req_o, 1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        #1;
        chk("w1_popped", mem_req_o, 0);
        chk("w1_inflight", empty_o, 0);
        mem_rvalid_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("w1_empty", empty_o, 1);

        // Fill: DEPTH+1 writes with memory stalled
        for (int i = 0; i < 4; i++) begin
            wr(32'h0010_0000 + 32'(4 * i), 32'(i + 1));
            #1;
            chk("fill_gnt", cache_gnt_o, 1);
            tick();
        end
        wr(32'h0010_0010, 32'h5);
        #1;
        chk("full_gnt", cache_gnt_o, 0);
        tick();
        chk("full_gnt2", cache_gnt_o, 0);
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        #1;
        chk("full_pop_gnt", cache_gnt_o, 0);
        chk("drain_d1", mem_wdata_o, 32'h1);
        tick();
        chk("after_pop_gnt", cache_gnt_o, 1);
        chk("drain_d2", mem_wdata_o, 32'h2);
        tick();
        cache_req_i = 1'b0;
        #1;
        chk("w5_rvalid", cache_rvalid_o, 1);
        chk("drain_d3", mem_wdata_o, 32'h3);
        tick();
        chk("drain_d4", mem_wdata_o, 32'h4);
        tick();
        chk("drain_d5", mem_wdata_o, 32'h5);
        chk("drain_a5", mem_addr_o, 32'h0010_0010);
        tick();
        chk("drain_done", mem_req_o, 0);
        chk("drain_inflight", empty_o, 0);
        mem_gnt_i = 1'b0;
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("fill_empty", empty_o, 1);

        // Read after write
        wr(32'h0010_0004, 32'hDEAD_BEEF);
        #1;
        chk("raw_wgnt", cache_gnt_o, 1);
        tick();
        cache_we_i = 1'b0;
        #1;
        chk("raw_drain_we", mem_we_o, 1);
        chk("raw_stall", cache_gnt_o, 0);
        mem_gnt_i = 1'b1;
        #1;
        chk("raw_stall2", cache_gnt_o, 0);
        tick();
        chk("raw_wait_rsp", mem_req_o, 0);
        chk("raw_wait_gnt", cache_gnt_o, 0);
        mem_rvalid_i = 1'b1;
        #1;
        chk("raw_rd_req", mem_req_o, 1);
        chk("raw_rd_we", mem_we_o, 0);
        chk("raw_rd_addr", mem_addr_o, 32'h0010_0004);
        chk("raw_rd_gnt", cache_gnt_o, 1);
        tick();
        mem_rvalid_i = 1'b0; cache_req_i = 1'b0;
        #1;
        chk("raw_pend_mreq", mem_req_o, 0);
        wr(32'h0010_0008, 32'h77);
        #1;
        chk("raw_pend_wgnt", cache_gnt_o, 0);
        cache_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        tick();
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
        chk("raw_rvalid", cache_rvalid_o, 1);
        chk("raw_rdata", cache_rdata_o, 32'hDEAD_BEEF);
        chk("raw_err", cache_error_o, 0);

        // Simultaneous push and pop at count 2
        wr(32'h100, 32'hA1);
        tick();
        wr(32'h104, 32'hB2);
        tick();
        wr(32'h108, 32'hC3);
        mem_gnt_i = 1'b1;
        #1;
        chk("pp_gnt", cache_gnt_o, 1);
        chk("pp_head", mem_wdata_o, 32'hA1);
        tick();
        cache_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        chk("pp_head2", mem_wdata_o, 32'hB2);
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        tick();
        chk("pp_head3", mem_wdata_o, 32'hC3);
        chk("pp_addr3", mem_addr_o, 32'h108);
        tick();
        chk("pp_nodup", mem_req_o, 0);
        mem_gnt_i = 1'b0;
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("pp_empty", empty_o, 1);

        // Write error is sticky; read error goes to cache_error_o only
        wr(32'h200, 32'h55);
        tick();
        cache_req_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_error_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0; mem_error_i = 1'b0;
        chk("we_sticky", wr_error_o, 1);
        chk("we_cache_err", cache_error_o, 0);
        tick();
        tick();
        chk("we_still", wr_error_o, 1);
        cache_req_i = 1'b1; cache_we_i = 1'b0; cache_addr_i = 32'h300; mem_gnt_i = 1'b1;
        #1;
        chk("re_gnt", cache_gnt_o, 1);
        tick();
        cache_req_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_error_i = 1'b1; mem_rdata_i = 32'hBAD;
        tick();
        mem_rvalid_i = 1'b0; mem_error_i = 1'b0;
        chk("re_rvalid", cache_rvalid_o, 1);
        chk("re_err", cache_error_o, 1);
        chk("re_rdata", cache_rdata_o, 32'hBAD);
        chk("re_wrerr", wr_error_o, 1);

        // Reset with three entries buffered
        for (int i = 0; i < 3; i++) begin
            wr(32'h400 + 32'(4 * i), 32'(16 + i));
            tick();
        end
        cache_req_i = 1'b0;
        #1;
        chk("rb_mreq", mem_req_o, 1);
        chk("rb_nempty", empty_o, 0);
        reset = 1'b1;
        #1;
        chk("rb_rst_mreq", mem_req_o, 0);
        chk("rb_rst_empty", empty_o, 1);
        chk("rb_rst_wrerr", wr_error_o, 0);
        tick();
        reset = 1'b0; mem_gnt_i = 1'b1;
        #1;
        chk("rb_post_mreq", mem_req_o, 0);
        chk("rb_post_empty", empty_o, 1);
        tick();
        chk("rb_post_mreq2", mem_req_o, 0);
        chk("rb_post_rvalid", cache_rvalid_o, 0);
        mem_gnt_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
